wt_mem_arbiter: RTL

- Parametrised N-channel memory-request arbiter that merges NumReq cache/master request streams (I$, D$, PTW, accelerators) onto one memory-side request channel.
- Tags each request with a channel index and routes returns back by ID.
- Tracks outstanding transactions per channel and supports drain and locked (AMO) sequences.
- Sits between the L1 caches and the memory adapter (AXI or L1.5). It generalises the fixed two-master I$/D$ plumbing to N channels.

---
 rtl/wt_cache_pkg.sv | 36 +++
 rtl/wt_rr_arb.sv | 47 ++++
 rtl/wt_mem_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/wt_cache_pkg.sv
// Shared types and constants for the write-through cache memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wt_cache_pkg;

  // Widths of the default memory-side configuration (64-bit address/data, 3 channels x 2-bit txid).
  localparam int unsigned MEM_ADDR_W = 64;
  localparam int unsigned MEM_DATA_W = 64;
  localparam int unsigned MEM_ID_W   = 4;

  // log2 byte-size encoding carried on the size field.
  localparam logic [2:0] SIZE_BYTE  = 3'd0;
  localparam logic [2:0] SIZE_HALF  = 3'd1;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [2:0] SIZE_DWORD = 3'd3;

  // Memory-side request and return records in the default configuration.
  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  we;
    logic [2:0]            size;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_ID_W-1:0]   id;
  } mem_arb_req_t;

  typedef struct packed {
    logic [MEM_ID_W-1:0]   id;
    logic [MEM_DATA_W-1:0] data;
  } mem_arb_rtrn_t;

  // Channel index width; a single channel still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wt_rr_arb.sv
// Single-grant arbiter: round-robin from a pointer, or fixed lowest-index priority.
// Latency: combinational grant; pointer updates on the clock after a grant.
// Backpressure: grants only among asserted requests; pointer frozen while hold_i is set.
module wt_rr_arb #(
  parameter int unsigned NumReq    = 3,
  parameter int unsigned IdxW      = 2,
  parameter bit          FixedPrio = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic              hold_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              gnt_vld_o
);

  logic [IdxW-1:0] r_ptr;

  // Search from the pointer (or from 0 in fixed mode); first asserted request wins.
  always_comb begin
    int unsigned w_c;
    w_c       = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      w_c = FixedPrio ? k : 32'(r_ptr) + k;
      if (w_c >= NumReq) w_c = w_c - NumReq;
      if (!gnt_vld_o && req_i[w_c[IdxW-1:0]]) begin
        gnt_vld_o               = 1'b1;
        gnt_idx_o               = w_c[IdxW-1:0];
        gnt_o[w_c[IdxW-1:0]]    = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner; a locked sequence keeps it where it was.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (gnt_vld_o && !hold_i) begin
      r_ptr <= (32'(gnt_idx_o) == NumReq - 1) ? '0 : gnt_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/wt_mem_arbiter.sv
// Merges NumReq request channels onto one tagged memory request port and routes returns by ID.
// Latency: request 1 cycle (grant -> mem_req_valid_o), return 1 cycle (mem_rtrn -> rtrn_valid_o).
// Backpressure: output stage holds until mem_req_ready_i; a channel at its outstanding limit is not granted.
module wt_mem_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumReq         = 3,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned TxIdWidth      = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          FixedPrio      = 1'b0,
  localparam int unsigned IdxW          = idx_width(NumReq),
  localparam int unsigned MemIdW        = IdxW + TxIdWidth,
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0]              req_we_i,
  input  logic [NumReq*3-1:0]            req_size_i,
  input  logic [NumReq*DataWidth-1:0]    req_wdata_i,
  input  logic [NumReq*TxIdWidth-1:0]    req_txid_i,
  input  logic [NumReq-1:0]              req_lock_i,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [AddrWidth-1:0]           mem_req_addr_o,
  output logic                           mem_req_we_o,
  output logic [2:0]                     mem_req_size_o,
  output logic [DataWidth-1:0]           mem_req_wdata_o,
  output logic [MemIdW-1:0]              mem_req_id_o,
  input  logic                           mem_rtrn_valid_i,
  input  logic [MemIdW-1:0]              mem_rtrn_id_i,
  input  logic [DataWidth-1:0]           mem_rtrn_data_i,
  output logic [NumReq-1:0]              rtrn_valid_o,
  output logic [TxIdWidth-1:0]           rtrn_txid_o,
  output logic [DataWidth-1:0]           rtrn_data_o,
  input  logic                           drain_i,
  output logic                           idle_o,
  output logic                           id_err_o
);

  // Output-stage record at this instance's widths (mirrors mem_arb_req_t).
  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [2:0]           size;
    logic [DataWidth-1:0] wdata;
    logic [MemIdW-1:0]    id;
  } stage_t;

  logic                         r_stage_vld;
  stage_t                       r_stage;
  logic [NumReq-1:0][CntW-1:0]  r_cnt;
  logic                         r_lock_vld;
  logic [IdxW-1:0]              r_lock_owner;
  logic [NumReq-1:0]            r_rtrn_vld;
  logic [TxIdWidth-1:0]         r_rtrn_txid;
  logic [DataWidth-1:0]         r_rtrn_data;
  logic                         r_id_err;
  logic                         r_idle;

  logic                         w_stage_free;
  logic [NumReq-1:0]            w_elig;
  logic [NumReq-1:0]            w_gnt;
  logic [IdxW-1:0]              w_gnt_idx;
  logic                         w_gnt_any;
  logic                         w_gnt_lock;
  stage_t                       w_gnt_req;
  logic [IdxW-1:0]              w_rtrn_idx;
  logic [NumReq-1:0]            w_rtrn_dec;
  logic                         w_rtrn_bad;
  logic [NumReq-1:0][CntW-1:0]  w_cnt_nxt;
  logic                         w_stage_vld_nxt;

  assign w_stage_free = !r_stage_vld || mem_req_ready_i;
  assign w_rtrn_idx   = mem_rtrn_id_i[MemIdW-1 -: IdxW];

  // Eligibility: credit left, not draining, stage can take it, and only the lock owner while locked.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NumReq; i++) begin
      w_elig[i] = req_valid_i[i] && (r_cnt[i] < CntW'(MaxOutstanding)) && !drain_i &&
                  w_stage_free && (!r_lock_vld || (r_lock_owner == IdxW'(i)));
    end
  end

  wt_rr_arb #(
    .NumReq    (NumReq),
    .IdxW      (IdxW),
    .FixedPrio (FixedPrio)
  ) u_rr_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (w_elig),
    .hold_i    (r_lock_vld),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx),
    .gnt_vld_o (w_gnt_any)
  );

  assign req_ready_o = w_gnt;
  assign w_gnt_lock  = |(w_gnt & req_lock_i);

  // Select the granted channel's fields and tag the ID with its channel index.
  always_comb begin
    w_gnt_req = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (w_gnt[i]) begin
        w_gnt_req.addr  = req_addr_i[i*AddrWidth +: AddrWidth];
        w_gnt_req.we    = req_we_i[i];
        w_gnt_req.size  = req_size_i[i*3 +: 3];
        w_gnt_req.wdata = req_wdata_i[i*DataWidth +: DataWidth];
        w_gnt_req.id    = {IdxW'(i), req_txid_i[i*TxIdWidth +: TxIdWidth]};
      end
    end
  end

  // Returns only count against a channel that actually has something outstanding.
  always_comb begin
    w_rtrn_dec = '0;
    for (int i = 0; i < NumReq; i++) begin
      w_rtrn_dec[i] = mem_rtrn_valid_i && (w_rtrn_idx == IdxW'(i)) && (r_cnt[i] != '0);
    end
    w_rtrn_bad = mem_rtrn_valid_i && !(|w_rtrn_dec);
  end

  // Next outstanding counts and stage occupancy, shared by the counters and idle flag.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      w_cnt_nxt[i] = r_cnt[i] + CntW'(w_gnt[i]) - CntW'(w_rtrn_dec[i]);
    end
    w_stage_vld_nxt = w_gnt_any || (r_stage_vld && !mem_req_ready_i);
  end

  // Output stage: load on grant, empty on handshake, otherwise hold stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stage_vld <= 1'b0;
      r_stage     <= '0;
    end else begin
      r_stage_vld <= w_stage_vld_nxt;
      if (w_gnt_any) r_stage <= w_gnt_req;
    end
  end

  // Outstanding counters and idle flag, registered from the next-state view.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_idle <= 1'b1;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_idle <= !w_stage_vld_nxt && (w_cnt_nxt == '0);
    end
  end

  // Lock owner: set by a locked grant, released by the owner's next unlocked grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock_vld   <= 1'b0;
      r_lock_owner <= '0;
    end else if (w_gnt_any) begin
      if (w_gnt_lock) begin
        r_lock_vld   <= 1'b1;
        r_lock_owner <= w_gnt_idx;
      end else begin
        r_lock_vld   <= 1'b0;
      end
    end
  end

  // Return stage: one-cycle strobe to the owning channel; bad IDs are dropped and flagged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rtrn_vld  <= '0;
      r_rtrn_txid <= '0;
      r_rtrn_data <= '0;
      r_id_err    <= 1'b0;
    end else begin
      r_rtrn_vld <= w_rtrn_dec;
      if (|w_rtrn_dec) begin
        r_rtrn_txid <= mem_rtrn_id_i[TxIdWidth-1:0];
        r_rtrn_data <= mem_rtrn_data_i;
      end
      if (w_rtrn_bad) r_id_err <= 1'b1;
    end
  end

  assign mem_req_valid_o = r_stage_vld;
  assign mem_req_addr_o  = r_stage.addr;
  assign mem_req_we_o    = r_stage.we;
  assign mem_req_size_o  = r_stage.size;
  assign mem_req_wdata_o = r_stage.wdata;
  assign mem_req_id_o    = r_stage.id;
  assign rtrn_valid_o    = r_rtrn_vld;
  assign rtrn_txid_o     = r_rtrn_txid;
  assign rtrn_data_o     = r_rtrn_data;
  assign idle_o          = r_idle;
  assign id_err_o        = r_id_err;

endmodule
